// File: rtl/fdivsqrt_pkg.sv
// Shared definitions for the radix-2 divide/square-root sequencer:
// FSM state type, precision encoding and per-format iteration counts.
package fdivsqrt_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ITER = 2'd1,
      DONE = 2'd2
   } state_e;

   localparam logic [1:0] FMT_H = 2'd0;
   localparam logic [1:0] FMT_S = 2'd1;
   localparam logic [1:0] FMT_D = 2'd2;
   localparam logic [1:0] FMT_Q = 2'd3;

   localparam int unsigned ITER_CNT_W = 7;

   // Radix-2 steps per precision, indexed by fmt (H, S, D, Q).
   localparam logic [ITER_CNT_W-1:0] N_ITER [4] = '{7'd13, 7'd26, 7'd55, 7'd115};

   function automatic logic [ITER_CNT_W-1:0] iter_count(input logic [1:0] fmt);
      logic [ITER_CNT_W-1:0] n;
      n = N_ITER[3];
      case (fmt)
         FMT_H: n = N_ITER[0];
         FMT_S: n = N_ITER[1];
         FMT_D: n = N_ITER[2];
         FMT_Q: n = N_ITER[3];
      endcase
      return n;
   endfunction

endpackage

// File: rtl/fdivsqrt_seq_if.sv
// Issue/writeback handshake and datapath-enable bundle of the div/sqrt
// sequencer. master = issue stage / datapath side, slave = sequencer.
interface fdivsqrt_seq_if;

   logic       start;
   logic       ready;
   logic       sqrt;
   logic [1:0] fmt;
   logic       special;
   logic       flush;
   logic       wz;
   logic       init;
   logic       iter_en;
   logic       last;
   logic       sqrt_q;
   logic       busy;
   logic       res_valid;
   logic       res_ready;
   logic       early;

   modport master (
      output start, sqrt, fmt, special, flush, wz, res_ready,
      input  ready, init, iter_en, last, sqrt_q, busy, res_valid, early
   );

   modport slave (
      input  start, sqrt, fmt, special, flush, wz, res_ready,
      output ready, init, iter_en, last, sqrt_q, busy, res_valid, early
   );

endinterface

// File: rtl/fdivsqrt_itercnt.sv
// Loadable down-counter for the iteration sequencer. Saturates at zero.
module fdivsqrt_itercnt #(
   parameter int unsigned CNT_W = 7
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   input  logic             en,
   output logic             zero
);

   logic [CNT_W-1:0] cnt;

   assign zero = (cnt == '0);

   // Load has priority over decrement; decrement holds at zero.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (en && !zero) begin
         cnt <= cnt - CNT_W'(1);
      end
   end

endmodule

// File: rtl/fdivsqrt_seq.sv
// Iteration sequencer for the radix-2 div/sqrt datapath: init strobe on
// accept, one iter_en per step for N[fmt] steps, then result-valid held
// until writeback accepts. Optional residual-zero early termination is
// enabled by defining FDIVSQRT_EARLY_TERM_EN.
module fdivsqrt_seq
   import fdivsqrt_pkg::*;
#(
   parameter int unsigned CNT_W = 7
) (
   input logic         clk,
   input logic         reset_n,
   fdivsqrt_seq_if.slave bus
);

   state_e           state, state_nx;
   logic             accept;
   logic             cnt_load;
   logic             cnt_zero;
   logic [CNT_W-1:0] cnt_init;
   logic             term_early;
   logic             early_q;
   logic             sqrt_r;
   logic             init_c;
   logic             iter_en_c;
   logic             res_valid_c;

   assign accept   = (state == IDLE) && bus.start && !bus.flush;
   // A flush also parks the counter at zero so no stale count survives.
   assign cnt_load = accept || bus.flush;
   assign cnt_init = (bus.flush || bus.special) ? '0
                   : CNT_W'(iter_count(bus.fmt) - ITER_CNT_W'(1));

`ifdef FDIVSQRT_EARLY_TERM_EN
   assign term_early = (state == ITER) && bus.wz && !bus.flush;
`else
   logic unused_wz;
   assign unused_wz  = bus.wz;
   assign term_early = 1'b0;
`endif

   fdivsqrt_itercnt #(
      .CNT_W (CNT_W)
   ) u_itercnt (
      .clk      (clk),
      .reset_n  (reset_n),
      .load     (cnt_load),
      .load_val (cnt_init),
      .en       (iter_en_c),
      .zero     (cnt_zero)
   );

   // State register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Next-state and strobe decode; flush overrides everything.
   always_comb begin
      state_nx    = state;
      init_c      = 1'b0;
      iter_en_c   = 1'b0;
      res_valid_c = 1'b0;
      unique case (state)
         IDLE: begin
            if (bus.start && !bus.flush) begin
               init_c   = 1'b1;
               state_nx = bus.special ? DONE : ITER;
            end
         end
         ITER: begin
            if (bus.flush) begin
               state_nx = IDLE;
            end else begin
               iter_en_c = 1'b1;
               if (cnt_zero || term_early) begin
                  state_nx = DONE;
               end
            end
         end
         DONE: begin
            if (bus.flush) begin
               state_nx = IDLE;
            end else begin
               res_valid_c = 1'b1;
               if (bus.res_ready) begin
                  state_nx = IDLE;
               end
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   // Operation type captured on accept; early flag set on residual-zero exit.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sqrt_r  <= 1'b0;
         early_q <= 1'b0;
      end else if (accept) begin
         sqrt_r  <= bus.sqrt;
         early_q <= 1'b0;
      end else if (bus.flush) begin
         early_q <= 1'b0;
      end else if (term_early) begin
         early_q <= 1'b1;
      end
   end

   assign bus.ready     = (state == IDLE);
   assign bus.busy      = (state == ITER);
   assign bus.last      = (state == ITER) && cnt_zero;
   assign bus.init      = init_c;
   assign bus.iter_en   = iter_en_c;
   assign bus.res_valid = res_valid_c;
   assign bus.sqrt_q    = sqrt_r;
   assign bus.early     = early_q;

endmodule

// File: tb/tb_fdivsqrt_seq.sv
// Self-checking bench for fdivsqrt_seq: directed vector table, hand-written
// flush/reset sequences and randomized operations against a cycle-count model.
module tb_fdivsqrt_seq;

   logic clk = 1'b0;
   logic reset_n = 1'b0;

   fdivsqrt_seq_if bus ();

   fdivsqrt_seq #(
      .CNT_W (7)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

`ifdef FDIVSQRT_EARLY_TERM_EN
   localparam bit EARLY = 1'b1;
`else
   localparam bit EARLY = 1'b0;
`endif

   typedef struct {
      bit sq;
      int f;
      bit sp;
      int wz_at;
      int rr;
      int fl_at;
      bit b2b;
      int e_iters;
      int e_last;
      int e_rv;
      int e_ret;
      int e_early;
   } vec_t;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic int n_of(input int f);
      case (f)
         0:       return 13;
         1:       return 26;
         2:       return 55;
         default: return 115;
      endcase
   endfunction

   // Expected behaviour from the operation rules, in whole-operation terms.
   function automatic vec_t model(input vec_t v);
      vec_t r;
      int n, e;
      r = v;
      n = n_of(v.f);
      if (v.sp) begin
         r.e_iters = 0; r.e_last = 0; r.e_rv = v.rr + 1;
         r.e_ret = v.rr + 2; r.e_early = 0;
      end else begin
         e = (EARLY && v.wz_at >= 1 && v.wz_at <= n) ? v.wz_at : n;
         if (v.fl_at != 0 && v.fl_at <= e) begin
            r.e_iters = v.fl_at - 1; r.e_last = (v.fl_at == n) ? 1 : 0;
            r.e_rv = 0; r.e_ret = v.fl_at + 1; r.e_early = 0;
         end else begin
            r.e_iters = e; r.e_last = (e == n) ? 1 : 0;
            r.e_rv = v.rr + 1; r.e_ret = e + 2 + v.rr;
            r.e_early = (EARLY && v.wz_at >= 1 && v.wz_at <= n) ? 1 : 0;
         end
      end
      return r;
   endfunction

   function automatic int outs();
      return int'({bus.ready, bus.busy, bus.res_valid, bus.iter_en,
                   bus.last, bus.sqrt_q, bus.early, bus.init});
   endfunction

   // One operation from IDLE; ends in the cycle where ready returns.
   task automatic run_op(input vec_t v, input string tag);
      int iters = 0, lasts = 0, last_cyc = 0, rv = 0, rv_first = 0;
      int ret = 0, seq_err = 0, sqq = -1, early_at_ret = -1, busy_end;
      if (!v.b2b) @(negedge clk);
      bus.start = 1'b1; bus.sqrt = v.sq; bus.fmt = 2'(v.f); bus.special = v.sp;
      bus.flush = 1'b0; bus.wz = 1'b0; bus.res_ready = 1'b0;
      #1;
      chk({tag, ".accept"}, int'({bus.ready, bus.init}), 3);
      busy_end = (v.fl_at != 0) ? v.fl_at : v.e_iters;
      for (int c = 1; c <= v.e_ret + 5; c++) begin
         @(negedge clk);
         bus.start     = (v.rr > 0 && v.e_rv > 0 && c == v.e_iters + 1);
         bus.sqrt      = ~v.sq;
         bus.special   = 1'b0;
         bus.wz        = (c == v.wz_at);
         bus.flush     = (c == v.fl_at);
         bus.res_ready = (rv >= v.rr);
         #1;
         if (c == 1) sqq = int'(bus.sqrt_q);
         if (bus.init) seq_err++;
         if (bus.busy != (c <= busy_end)) seq_err++;
         if (bus.iter_en) iters++;
         if (bus.last) begin lasts++; last_cyc = c; end
         if (bus.res_valid) begin
            if (rv == 0) rv_first = c;
            rv++;
         end
         if (bus.ready) begin
            ret = c;
            early_at_ret = int'(bus.early);
            break;
         end
      end
      bus.start = 1'b0; bus.wz = 1'b0; bus.flush = 1'b0;
      chk({tag, ".iters"}, iters, v.e_iters);
      chk({tag, ".last_count"}, lasts, v.e_last);
      if (v.e_last != 0) chk({tag, ".last_cycle"}, last_cyc, n_of(v.f));
      chk({tag, ".res_valid_len"}, rv, v.e_rv);
      if (v.e_rv != 0) chk({tag, ".res_valid_cycle"}, rv_first, v.e_iters + 1);
      chk({tag, ".ready_cycle"}, ret, v.e_ret);
      chk({tag, ".sqrt_q"}, sqq, int'(v.sq));
      chk({tag, ".early"}, early_at_ret, v.e_early);
      chk({tag, ".protocol"}, seq_err, 0);
   endtask

   vec_t tbl [8];
   vec_t rv_vec;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.start = 1'b0; bus.sqrt = 1'b0; bus.fmt = 2'd0; bus.special = 1'b0;
      bus.flush = 1'b0; bus.wz = 1'b0; bus.res_ready = 1'b0;

      //          sq f  sp wz  rr fl  b2b iters last rv ret early
      tbl[0] = '{0, 2, 0, 0,  0, 0,  0,  55,  1,  1, 57, 0};
      tbl[1] = '{1, 0, 0, 0,  5, 0,  0,  13,  1,  6, 20, 0};
      tbl[2] = '{0, 1, 0, 0,  0, 0,  1,  26,  1,  1, 28, 0};
      tbl[3] = '{0, 3, 1, 0,  0, 0,  0,   0,  0,  1,  2, 0};
      tbl[4] = '{1, 3, 0, 0,  0, 20, 0,  19,  0,  0, 21, 0};
      tbl[5] = '{0, 0, 0, 0,  0, 0,  1,  13,  1,  1, 15, 0};
`ifdef FDIVSQRT_EARLY_TERM_EN
      tbl[6] = '{0, 2, 0, 10, 0, 0,  0,  10,  0,  1, 12, 1};
`else
      tbl[6] = '{0, 2, 0, 10, 0, 0,  0,  55,  1,  1, 57, 0};
`endif
      tbl[7] = '{1, 1, 1, 0,  2, 0,  0,   0,  0,  3,  4, 0};

      #3;
      chk("reset.outputs", outs(), 128);
      @(negedge clk);
      reset_n = 1'b1;

      for (int i = 0; i < 8; i++) begin
         run_op(tbl[i], $sformatf("vec%0d", i));
      end

      // start and flush together in IDLE: flush wins.
      @(negedge clk);
      bus.start = 1'b1; bus.flush = 1'b1; bus.fmt = 2'd0; bus.special = 1'b0;
      #1;
      chk("flush_vs_start.init", int'(bus.init), 0);
      @(negedge clk);
      bus.start = 1'b0; bus.flush = 1'b0;
      #1;
      chk("flush_vs_start.state", int'({bus.ready, bus.busy}), 2);

      for (int i = 0; i < 24; i++) begin
         rv_vec.sq    = 1'($urandom_range(0, 1));
         rv_vec.f     = int'($urandom_range(0, 3));
         rv_vec.sp    = ($urandom_range(0, 4) == 0);
         rv_vec.rr    = int'($urandom_range(0, 3));
         rv_vec.b2b   = (i > 0) && ($urandom_range(0, 1) == 1);
         rv_vec.fl_at = 0;
         rv_vec.wz_at = 0;
         if (!rv_vec.sp && $urandom_range(0, 3) == 0)
            rv_vec.fl_at = int'($urandom_range(1, n_of(rv_vec.f)));
         if ($urandom_range(0, 1) == 1) begin
            if (rv_vec.fl_at != 0)
               rv_vec.wz_at = rv_vec.fl_at + int'($urandom_range(0, 3));
            else
               rv_vec.wz_at = int'($urandom_range(1, n_of(rv_vec.f) + 3));
         end
         rv_vec = model(rv_vec);
         run_op(rv_vec, $sformatf("rnd%0d", i));
      end

      // Asynchronous reset in the middle of a D sqrt.
      @(negedge clk);
      bus.start = 1'b1; bus.sqrt = 1'b1; bus.fmt = 2'd2; bus.special = 1'b0;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (8) @(negedge clk);
      #1;
      chk("async_reset.pre", int'({bus.busy, bus.iter_en, bus.sqrt_q}), 7);
      #2;
      reset_n = 1'b0;
      #1;
      chk("async_reset.outputs", outs(), 128);
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      #1;
      chk("async_reset.after", outs(), 128);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/fdivsqrt_seq.md
# fdivsqrt_seq

Iteration sequencer for the radix-2 divide/square-root datapath. Accepts an operation from the FPU issue stage, pulses the datapath's initial-load strobe, and asserts one iteration enable per cycle for a format-dependent number of steps. Each step covers the F addend generation, residual update and U/UM quotient-register update. It then holds a result-valid flag until the writeback stage accepts it. It sits beside the residual/quotient registers inside the div/sqrt unit and is the only source of their enables.

## Interface
Parameters:
- `CNT_W`, default 7: iteration-counter width; must hold the largest entry of the iteration table.

Ports:
- `clk`  input  1  clock, rising-edge active.
- `reset_n`  input  1  reset, asynchronous, active-low.
- `start`  input  1  request a new operation; qualified by `ready`.
- `ready`  output  1  sequencer idle and able to accept `start`.
- `sqrt`  input  1  operation is square root; sampled on accept and held in `sqrt_q`.
- `fmt`  input  2  precision, 0=H, 1=S, 2=D, 3=Q; sampled on accept.
- `special`  input  1  operands are special (NaN, Inf, zero); sampled on accept; no iterations run.
- `flush`  input  1  abandon any operation in flight.
- `wz`  input  1  residual-is-zero indication from the datapath, valid in each iteration cycle.
- `init`  output  1  load initial residual, C, U and UM.
- `iter_en`  output  1  advance residual, C, U and UM by one radix-2 step.
- `last`  output  1  current iteration is the final one.
- `sqrt_q`  output  1  registered operation type.
- `busy`  output  1  in ITER state.
- `res_valid`  output  1  result registers are final.
- `res_ready`  input  1  writeback accepts the result.
- `early`  output  1  operation ended through residual-zero early termination.

## Operation
- States: IDLE, ITER, DONE; reset state IDLE.
- Iteration table N[fmt], in the shared package: H=13, S=26, D=55, Q=115.
- IDLE:
  - `ready`=1.
  - On `start` with `special`=0: `init`=1 in the same cycle (combinational); load count with N[fmt]−1; go to ITER.
  - On `start` with `special`=1: `init`=1; go straight to DONE.
- ITER:
  - `iter_en`=1 every cycle.
  - Count decrements each cycle; `last`=1 when count==0.
  - Move to DONE after the cycle with `last`=1.
- DONE:
  - `res_valid`=1.
  - When `res_valid` and `res_ready` are both high, go to IDLE.
  - `ready` is 0 in DONE; no start-to-done bypass.
- `flush` has the highest priority. In any state it forces IDLE on the next edge; `iter_en`, `init` and `res_valid` are forced to 0 in the flush cycle. If `start` and `flush` are both high in IDLE, `flush` wins and the start is not accepted.
- `start` while `ready`=0 is ignored and is not queued.
- Count arithmetic is unsigned, with no wrap: the decrement is suppressed at 0.
- Asynchronous reset mid-operation returns to IDLE immediately with all outputs at reset values. The datapath contents become don't-care.

## Timing
- Reset values:
  - `ready`=1.
  - `busy`=0, `res_valid`=0, `iter_en`=0, `last`=0.
  - `sqrt_q`=0, `early`=0, count=0.
  - `init` follows `start` and is therefore 0 while `start`=0.
- Latency: with accept at edge 0, `iter_en` is high in cycles 1..N and `res_valid` rises in cycle N+1.
  - D: 55 iteration cycles, so `res_valid` rises at cycle 56.
  - Special operation: `res_valid` rises at cycle 1.
- With `res_ready` held high, `res_valid` lasts one cycle and `ready` returns the following cycle. Back-to-back throughput is N+2 cycles per operation.
- `last`, `busy` and `res_valid` are decoded from registered state only. `init` is the only combinational path, from `start`.

## Configuration
- Macro: `FDIVSQRT_EARLY_TERM_EN`.
- Defined:
  - In ITER, `wz`=1 with `iter_en`=1 ends the operation: the next state is DONE regardless of the count.
  - `early` is set on that transition and cleared on the next accept or on flush.
- Undefined:
  - `wz` is ignored and `early` is tied to 0.
  - Every operation takes the full N[fmt] iterations.

## Structure
- Shared package `fdivsqrt_pkg` holds:
  - the state enum (IDLE, ITER, DONE);
  - the `fmt` encoding constants;
  - the iteration table N[fmt] as a localparam array sized by `CNT_W`.
- One sub-module, `fdivsqrt_itercnt`: loadable down-counter with load, enable and zero-flag outputs. The FSM stays in the top module.

## Test plan
- Reset, then a D divide with `start`=1 for one cycle and `res_ready`=1 -> `init` pulses at cycle 0, `iter_en` is high for exactly 55 cycles, `last` is high only in cycle 55, `res_valid` is high in cycle 56 only, and `ready` is 1 at cycle 57.
- H sqrt, then S divide back-to-back, with `res_ready` held low for 5 cycles on the first op -> 13 iterations, then `res_valid` holds for 6 cycles; a `start` presented during DONE is ignored; the second op runs 26 iterations and `sqrt_q`=0.
- `special`=1 with Q format -> no `iter_en`; `res_valid` at cycle 1.
- `flush` at iteration 20 of a Q op -> IDLE next cycle and `iter_en` low in the flush cycle. A new H op is accepted on the following `start` and completes in 13 iterations.
- With `FDIVSQRT_EARLY_TERM_EN`: `wz`=1 at iteration 10 of D -> DONE at cycle 11 with `early`=1. Without the macro, the same stimulus runs 55 iterations with `early`=0.
- `reset_n` asserted mid-ITER, asynchronous to `clk` -> outputs return to reset values immediately; after release, `ready`=1.
